// File: rtl/stack_burst_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : stack_burst_engine_if
//  Brief    : Command, push/pop stream and memory-port bundle for the stack
//             burst engine. The engine sits on the slave modport; the core
//             and memory side use master.
//  Revision : 1.0  initial release
// ============================================================================
interface stack_burst_engine_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4,
   parameter int CNT_W  = 7
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_pop;
   logic [LEN_W-1:0]  cmd_len;
   logic              push_valid;
   logic              push_ready;
   logic [DATA_W-1:0] push_data;
   logic              pop_valid;
   logic [DATA_W-1:0] pop_data;
   logic              sp_load;
   logic [ADDR_W-1:0] sp_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_own;
   logic [ADDR_W-1:0] sp;
   logic [CNT_W-1:0]  count;
   logic              done;
   logic              ovf;
   logic              unf;

   modport slave (
      input  cmd_valid, cmd_pop, cmd_len, push_valid, push_data,
             sp_load, sp_wdata, mem_rdata,
      output cmd_ready, push_ready, pop_valid, pop_data, mem_we, mem_re,
             mem_addr, mem_wdata, bus_own, sp, count, done, ovf, unf
   );

   modport master (
      output cmd_valid, cmd_pop, cmd_len, push_valid, push_data,
             sp_load, sp_wdata, mem_rdata,
      input  cmd_ready, push_ready, pop_valid, pop_data, mem_we, mem_re,
             mem_addr, mem_wdata, bus_own, sp, count, done, ovf, unf
   );
endinterface
`default_nettype wire

// File: rtl/stack_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module   : stack_burst_engine
//  Brief    : Memory-backed full-descending hardware stack. Runs multi-word
//             PUSH/POP bursts against data memory, rejects bursts that would
//             overflow/underflow before touching memory, exposes SP and depth.
//  Revision : 1.0  initial release
// ============================================================================
module stack_burst_engine #(
   parameter int              DATA_W   = 16,
   parameter int              ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] SP_RESET = 16'hFFFE,
   parameter int              STEP     = 2,
   parameter int              DEPTH    = 64,
   parameter int              LEN_W    = 4,
   parameter int              RD_LAT   = 1
) (
   input  wire logic           clk,
   input  wire logic           rst,
   stack_burst_engine_if.slave bus
);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WAIT_W = $clog2(RD_LAT + 1);
   localparam logic [ADDR_W-1:0] c_STEP    = ADDR_W'(STEP);
   localparam logic [LEN_W-1:0]  c_REM_ONE = LEN_W'(1);
   localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
   localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(RD_LAT);
   localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PUSH     = 3'd1,
      S_POP_RD   = 3'd2,
      S_POP_WAIT = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_sp;
   logic [CNT_W-1:0]  r_count;
   logic [LEN_W-1:0]  r_rem;
   logic [WAIT_W-1:0] r_wait;
   logic [DATA_W-1:0] r_pop_data;
   logic              r_pop_valid, r_ovf, r_unf;

   logic              w_accept, w_ovf_hit, w_unf_hit, w_rd_last;
   logic [31:0]       w_cnt_plus;
   logic [ADDR_W-1:0] w_load_cnt;
   logic              w_cmd_ready, w_push_ready, w_we, w_re, w_bus_own, w_done;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   // Command admission and the room/entry checks made in the accept cycle
   assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
   assign w_cnt_plus = 32'(r_count) + 32'(bus.cmd_len);
   assign w_ovf_hit  = w_accept && !bus.cmd_pop && (w_cnt_plus > 32'(DEPTH));
   assign w_unf_hit  = w_accept && bus.cmd_pop && (32'(bus.cmd_len) > 32'(r_count));
   assign w_rd_last  = (r_state == S_POP_WAIT) && (r_wait == c_WAIT_LAST);
   assign w_load_cnt = (SP_RESET - bus.sp_wdata) / c_STEP;

   // State register; reset drops straight back to IDLE from any state
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and memory-port decode; strobes are masked by rst so a reset
   // mid-burst issues no further access even in the reset cycle itself
   always_comb begin
      w_next       = r_state;
      w_cmd_ready  = 1'b0;
      w_push_ready = 1'b0;
      w_we         = 1'b0;
      w_re         = 1'b0;
      w_addr       = r_sp;
      w_wdata      = '0;
      w_bus_own    = 1'b1;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            w_bus_own   = 1'b0;
            if (w_accept && !w_ovf_hit && !w_unf_hit) begin
               if (bus.cmd_len == '0) w_next = S_DONE;
               else if (bus.cmd_pop)  w_next = S_POP_RD;
               else                   w_next = S_PUSH;
            end
         end
         S_PUSH: begin
            w_push_ready = 1'b1;
            w_addr       = r_sp - c_STEP;
            w_wdata      = bus.push_data;
            if (bus.push_valid) begin
               w_we = !rst;
               if (r_rem == c_REM_ONE) w_next = S_DONE;
            end
         end
         S_POP_RD: begin
            w_re   = !rst;
            w_next = S_POP_WAIT;
         end
         S_POP_WAIT: begin
            if (w_rd_last) w_next = (r_rem == c_REM_ONE) ? S_DONE : S_POP_RD;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Stack pointer, depth, burst counters and the registered pop/error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp        <= SP_RESET;
         r_count     <= '0;
         r_rem       <= '0;
         r_wait      <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_pop_valid <= 1'b0;
         r_ovf       <= w_ovf_hit;
         r_unf       <= w_unf_hit;
         case (r_state)
            S_IDLE: begin
               // an accepted command takes priority over an SP load
               if (w_accept) begin
                  r_rem <= bus.cmd_len;
               end else if (bus.sp_load) begin
                  r_sp    <= bus.sp_wdata;
                  r_count <= w_load_cnt[CNT_W-1:0];
               end
            end
            S_PUSH: begin
               if (bus.push_valid) begin
                  r_sp    <= r_sp - c_STEP;
                  r_count <= r_count + c_CNT_ONE;
                  r_rem   <= r_rem - c_REM_ONE;
               end
            end
            S_POP_RD: r_wait <= c_WAIT_ONE;
            S_POP_WAIT: begin
               if (w_rd_last) begin
                  r_pop_data  <= bus.mem_rdata;
                  r_pop_valid <= 1'b1;
                  r_sp        <= r_sp + c_STEP;
                  r_count     <= r_count - c_CNT_ONE;
                  r_rem       <= r_rem - c_REM_ONE;
               end else begin
                  r_wait <= r_wait + c_WAIT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready  = w_cmd_ready;
   assign bus.push_ready = w_push_ready;
   assign bus.pop_valid  = r_pop_valid;
   assign bus.pop_data   = r_pop_data;
   assign bus.mem_we     = w_we;
   assign bus.mem_re     = w_re;
   assign bus.mem_addr   = w_addr;
   assign bus.mem_wdata  = w_wdata;
   assign bus.bus_own    = w_bus_own;
   assign bus.sp         = r_sp;
   assign bus.count      = r_count;
   assign bus.done       = w_done;
   assign bus.ovf        = r_ovf;
   assign bus.unf        = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_stack_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_burst_engine
//  Brief    : Directed bench for stack_burst_engine. Instance A uses default
//             parameters, instance B uses DEPTH=4 / RD_LAT=3. Expected writes,
//             reads and popped words are queued as stimulus is driven and
//             compared by a monitor when the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stack_burst_engine;
   localparam int CW_A = $clog2(64 + 1);
   localparam int CW_B = $clog2(4 + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        cmd_valid = 1'b0, cmd_pop = 1'b0, push_valid = 1'b0, sp_load = 1'b0;
   logic [3:0]  cmd_len = '0;
   logic [15:0] push_data = '0, sp_wdata = '0;

   always #5 clk = ~clk;

   stack_burst_engine_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(4), .CNT_W(CW_A)) ifa ();
   stack_burst_engine_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(4), .CNT_W(CW_B)) ifb ();

   assign ifa.cmd_valid  = cmd_valid & ~sel;
   assign ifb.cmd_valid  = cmd_valid & sel;
   assign ifa.push_valid = push_valid & ~sel;
   assign ifb.push_valid = push_valid & sel;
   assign ifa.sp_load    = sp_load & ~sel;
   assign ifb.sp_load    = sp_load & sel;
   assign ifa.cmd_pop    = cmd_pop;
   assign ifb.cmd_pop    = cmd_pop;
   assign ifa.cmd_len    = cmd_len;
   assign ifb.cmd_len    = cmd_len;
   assign ifa.push_data  = push_data;
   assign ifb.push_data  = push_data;
   assign ifa.sp_wdata   = sp_wdata;
   assign ifb.sp_wdata   = sp_wdata;

   stack_burst_engine u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
   stack_burst_engine #(.DEPTH(4), .RD_LAT(3)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Memory models: read data is valid only exactly RD_LAT cycles after mem_re
   logic [15:0] mem_a [0:65535];
   logic [15:0] mem_b [0:65535];
   logic [15:0] rd_a = 16'hDEAD, s1_b = 16'hDEAD, s2_b = 16'hDEAD, s3_b = 16'hDEAD;
   always @(posedge clk) begin
      if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
      rd_a <= ifa.mem_re ? mem_a[ifa.mem_addr] : 16'hDEAD;
      if (ifb.mem_we) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
      s1_b <= ifb.mem_re ? mem_b[ifb.mem_addr] : 16'hDEAD;
      s2_b <= s1_b;
      s3_b <= s2_b;
   end
   assign ifa.mem_rdata = rd_a;
   assign ifb.mem_rdata = s3_b;

   // Observed outputs of the selected instance
   logic        w_cmd_ready, w_push_ready, w_pv, w_we, w_re, w_own, w_done, w_ovf, w_unf;
   logic [15:0] w_pdata, w_addr, w_wdata, w_sp;
   logic [7:0]  w_count;
   assign w_cmd_ready  = sel ? ifb.cmd_ready  : ifa.cmd_ready;
   assign w_push_ready = sel ? ifb.push_ready : ifa.push_ready;
   assign w_pv         = sel ? ifb.pop_valid  : ifa.pop_valid;
   assign w_pdata      = sel ? ifb.pop_data   : ifa.pop_data;
   assign w_we         = sel ? ifb.mem_we     : ifa.mem_we;
   assign w_re         = sel ? ifb.mem_re     : ifa.mem_re;
   assign w_addr       = sel ? ifb.mem_addr   : ifa.mem_addr;
   assign w_wdata      = sel ? ifb.mem_wdata  : ifa.mem_wdata;
   assign w_own        = sel ? ifb.bus_own    : ifa.bus_own;
   assign w_sp         = sel ? ifb.sp         : ifa.sp;
   assign w_count      = sel ? 8'(ifb.count)  : 8'(ifa.count);
   assign w_done       = sel ? ifb.done       : ifa.done;
   assign w_ovf        = sel ? ifb.ovf        : ifa.ovf;
   assign w_unf        = sel ? ifb.unf        : ifa.unf;

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;
   logic [31:0] exp_wr[$];
   logic [15:0] exp_rd[$];
   logic [15:0] exp_pop[$];
   logic [15:0] m_stack[$];
   logic [15:0] m_sp;
   int          pv_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Scoreboard monitor: every strobe and popped word must match a queued expectation
   always @(negedge clk) begin
      if (w_we || w_re) chk("bus_own_excl", {30'd0, w_own, w_we & w_re}, 32'h2);
      if (w_we) begin
         chk("we_expected", 32'(exp_wr.size() > 0), 32'd1);
         if (exp_wr.size() > 0) chk("wr_addr_data", {w_addr, w_wdata}, exp_wr.pop_front());
      end
      if (w_re) begin
         chk("re_expected", 32'(exp_rd.size() > 0), 32'd1);
         if (exp_rd.size() > 0) chk("rd_addr", 32'(w_addr), 32'(exp_rd.pop_front()));
      end
      if (w_pv) begin
         pv_cyc.push_back(cyc_n);
         chk("pop_expected", 32'(exp_pop.size() > 0), 32'd1);
         if (exp_pop.size() > 0) chk("pop_data", 32'(w_pdata), 32'(exp_pop.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input int len, input logic [15:0] base, input logic [15:0] inc);
      cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_len = len[3:0];
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         push_data  = 16'(base + i * inc);
         push_valid = 1'b1;
         m_sp       = m_sp - 16'd2;
         exp_wr.push_back({m_sp, push_data});
         m_stack.push_front(push_data);
         cyc();
      end
      push_valid = 1'b0;
      @(negedge clk);
      chk("push_done", 32'(w_done), 32'd1);
      cyc();
   endtask

   task automatic pop_burst(input int len, input int rd_lat);
      int n;
      cmd_valid = 1'b1; cmd_pop = 1'b1; cmd_len = len[3:0];
      for (int i = 0; i < len; i++) begin
         exp_rd.push_back(m_sp);
         exp_pop.push_back(m_stack.pop_front());
         m_sp = m_sp + 16'd2;
      end
      pv_cyc.delete();
      cyc();
      cmd_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (w_done !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("pop_cycles", 32'(n), 32'(len * (rd_lat + 1)));
      cyc();
      chk("pop_drained", 32'(exp_pop.size() + exp_rd.size()), 32'd0);
      chk("pop_count", 32'(pv_cyc.size()), 32'(len));
      for (int i = 1; i < pv_cyc.size(); i++)
         chk("pop_spacing", 32'(pv_cyc[i] - pv_cyc[i-1]), 32'(rd_lat + 1));
   endtask

   initial begin
      m_sp = 16'hFFFE;
      // 1: reset held two cycles
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sp", 32'(w_sp), 32'hFFFE);
      chk("rst_count", 32'(w_count), 32'd0);
      chk("rst_ready", 32'(w_cmd_ready), 32'd1);
      chk("rst_strobes", {28'd0, w_we, w_re, w_own, w_push_ready}, 32'd0);
      chk("rst_pulses", {28'd0, w_done, w_ovf, w_unf, w_pv}, 32'd0);
      chk("rst_pop_data", 32'(w_pdata), 32'd0);
      cyc();

      // 2: PUSH 3 words
      push_burst(3, 16'h1111, 16'h1111);
      @(negedge clk);
      chk("push_sp", 32'(w_sp), 32'hFFF8);
      chk("push_count", 32'(w_count), 32'd3);
      chk("push_idle", {30'd0, w_cmd_ready, w_own}, 32'h2);
      cyc();

      // 3: POP 3 words, RD_LAT=1
      pop_burst(3, 1);
      @(negedge clk);
      chk("pop_sp", 32'(w_sp), 32'hFFFE);
      chk("pop_count_end", 32'(w_count), 32'd0);
      cyc();

      // SP load, and SP load losing to an accepted zero-length command
      sp_load = 1'b1; sp_wdata = 16'hFFF0;
      cyc();
      sp_load = 1'b0;
      @(negedge clk);
      chk("load_sp", 32'(w_sp), 32'hFFF0);
      chk("load_count", 32'(w_count), 32'd7);
      cyc();
      sp_load = 1'b1; sp_wdata = 16'hFF00;
      cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_len = 4'd0;
      cyc();
      sp_load = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      chk("noop_done", 32'(w_done), 32'd1);
      chk("noop_sp_kept", 32'(w_sp), 32'hFFF0);
      cyc();
      sp_load = 1'b1; sp_wdata = 16'hFFFE;
      cyc();
      sp_load = 1'b0;
      @(negedge clk);
      chk("reload_count", 32'(w_count), 32'd0);
      cyc();

      // 6: reset mid PUSH len=5 after 2 words, with a stall and a stray sp_load
      m_sp = 16'hFFFE;
      sp_load = 1'b1; sp_wdata = 16'h1234;
      cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_len = 4'd5;
      cyc();
      cmd_valid = 1'b0;
      push_data = 16'hAAA0; push_valid = 1'b1;
      m_sp = m_sp - 16'd2; exp_wr.push_back({m_sp, push_data});
      cyc();
      push_valid = 1'b0;
      @(negedge clk);
      chk("stall_state", {29'd0, w_push_ready, w_own, w_we}, 32'h6);
      chk("stall_sp", 32'(w_sp), 32'hFFFC);
      cyc();
      push_data = 16'hAAA1; push_valid = 1'b1;
      m_sp = m_sp - 16'd2; exp_wr.push_back({m_sp, push_data});
      cyc();
      sp_load = 1'b0; rst = 1'b1; push_data = 16'hAAA2;
      @(negedge clk);
      chk("rst_cycle_we", 32'(w_we), 32'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle", {30'd0, w_cmd_ready, w_own}, 32'h2);
      chk("abort_sp", 32'(w_sp), 32'hFFFE);
      chk("abort_count", 32'(w_count), 32'd0);
      cyc(); cyc();
      push_valid = 1'b0;
      chk("kept_word0", 32'(mem_a[16'hFFFC]), 32'hAAA0);
      chk("kept_word1", 32'(mem_a[16'hFFFA]), 32'hAAA1);

      // 4: instance B (DEPTH=4, RD_LAT=3) overflow with count=3
      sel = 1'b1; m_sp = 16'hFFFE; m_stack.delete();
      cyc();
      push_burst(3, 16'h0B01, 16'h0001);
      cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_len = 4'd2;
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("ovf_pulse", 32'(w_ovf), 32'd1);
      chk("ovf_sp", 32'(w_sp), 32'hFFF8);
      chk("ovf_count", 32'(w_count), 32'd3);
      chk("ovf_idle", 32'(w_cmd_ready), 32'd1);
      cyc();
      @(negedge clk);
      chk("ovf_single", 32'(w_ovf), 32'd0);
      cyc();
      push_burst(1, 16'h0B04, 16'h0001);
      @(negedge clk);
      chk("full_count", 32'(w_count), 32'd4);
      cyc();

      // 5: POP bursts with RD_LAT=3
      pop_burst(2, 3);
      pop_burst(2, 3);
      @(negedge clk);
      chk("b_empty_sp", 32'(w_sp), 32'hFFFE);
      cyc();
      // empty POP -> underflow
      cmd_valid = 1'b1; cmd_pop = 1'b1; cmd_len = 4'd1;
      cyc();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("unf_pulse", 32'(w_unf), 32'd1);
      chk("unf_sp", 32'(w_sp), 32'hFFFE);
      chk("unf_idle", {30'd0, w_cmd_ready, w_own}, 32'h2);
      cyc(); cyc();
      chk("queues_empty", 32'(exp_wr.size() + exp_rd.size() + exp_pop.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
